// File: rtl/stream_demux_reg_pkg.sv
// stream_demux_reg_pkg: default parameters and channel slice helper for the stream demux
package stream_demux_reg_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_SEL_W  = 2;
    localparam int DEF_DROP_W = 8;
    function automatic int ch_lo(input int c, input int w);
        return c * w;
    endfunction
endpackage

// File: rtl/stream_demux_reg_ch.sv
// stream_demux_reg_ch: one-entry output register slice with drain and same-cycle reload
module stream_demux_reg_ch #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] q
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] q_q, q_d;
    always_comb begin
        valid_d = load | (valid_q & ~ready);
        q_d     = load ? d : q_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            q_q     <= '0;
        end else begin
            valid_q <= valid_d;
            q_q     <= q_d;
        end
    end
    assign valid = valid_q;
    assign q     = q_q;
endmodule

// File: rtl/stream_demux_reg.sv
// stream_demux_reg: registered 1-to-NUM_CH stream demux with broadcast and out-of-range drop counting
module stream_demux_reg
    import stream_demux_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [DROP_W-1:0]        drop_cnt
);
    logic [NUM_CH-1:0] free, tgt, load;
    logic              in_range, accept, drop;
    logic [DROP_W-1:0] drop_q, drop_d;
    // out-of-range unicasts target no channel and are always accepted
    always_comb begin
        free     = ~out_valid | out_ready;
        in_range = 32'(in_sel) < NUM_CH;
        tgt      = in_bcast ? '1 : in_range ? NUM_CH'(1) << in_sel : '0;
        in_ready = ~rst & (in_bcast ? &free : in_range ? |(tgt & free) : 1'b1);
        accept   = in_valid & in_ready;
        load     = accept ? tgt : '0;
        drop     = accept & ~in_bcast & ~in_range;
        drop_d   = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end
    assign drop_cnt = drop_q;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        stream_demux_reg_ch #(.DATA_W(DATA_W)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .load  (load[c]),
            .d     (in_data),
            .ready (out_ready[c]),
            .valid (out_valid[c]),
            .q     (out_data[ch_lo(c, DATA_W) +: DATA_W])
        );
    end
endmodule
